vec_feeder: RTL

Serial-to-parallel front end for the `vec_mul` dot-product engine. It accepts one `(x, k)` element pair per cycle over a valid/ready stream and packs C pairs into lane vectors. It presents those vectors to `vec_mul` through a registered valid/ready output stage with one extra buffer. A latency-matched delay line marks which `vec_mul` result cycles carry valid `y` values.

---
 rtl/vec_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vec_feeder.sv
// Serial-to-parallel packer feeding vec_mul: collects (x, k) pairs into C-lane vectors,
// buffers up to two complete vectors, and tags the vec_mul result cycles via a delay line.
module vec_feeder #(
    parameter int C       = 16,
    parameter int W_X     = 8,
    parameter int W_K     = 8,
    parameter int LATENCY = $clog2(C) + 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [W_X-1:0]            s_x,
    input  logic [W_K-1:0]            s_k,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [C-1:0][W_X-1:0]     m_x,
    output logic [C-1:0][W_K-1:0]     m_k,
    output logic                      m_last,
    output logic                      y_valid,
    output logic                      y_last
);

    localparam int CW = $clog2(C);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [C-1:0][W_X-1:0]  fx_q;
    logic [C-1:0][W_K-1:0]  fk_q;
    logic                   hold_last_q;

    logic                   m_valid_q;
    logic [C-1:0][W_X-1:0]  m_x_q;
    logic [C-1:0][W_K-1:0]  m_k_q;
    logic                   m_last_q;

    logic [LATENCY-1:0]     dv_q;
    logic [LATENCY-1:0]     dl_q;

    logic [C-1:0][W_X-1:0]  px_d;
    logic [C-1:0][W_K-1:0]  pk_d;

    logic accept;
    logic complete;
    logic out_free;
    logic xfer;

    assign s_ready  = rstn && (state_q == FILL);
    assign accept   = s_valid && s_ready;
    assign complete = accept && ((cnt_q == CW'(C - 1)) || s_last);
    assign out_free = !m_valid_q || m_ready;
    assign xfer     = m_valid_q && m_ready;

    // Fill buffer with the incoming element merged into lane cnt.
    always_comb begin
        px_d        = fx_q;
        pk_d        = fk_q;
        px_d[cnt_q] = s_x;
        pk_d[cnt_q] = s_k;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            fx_q        <= '0;
            fk_q        <= '0;
            hold_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_x_q       <= '0;
            m_k_q       <= '0;
            m_last_q    <= 1'b0;
            dv_q        <= '0;
            dl_q        <= '0;
        end else begin
            dv_q[0] <= xfer;
            dl_q[0] <= xfer && m_last_q;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dv_q[i] <= dv_q[i-1];
                dl_q[i] <= dl_q[i-1];
            end

            // A load below overrides this drain, keeping m_valid high across back-to-back vectors.
            if (xfer) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (complete) begin
                            if (out_free) begin
                                m_valid_q <= 1'b1;
                                m_x_q     <= px_d;
                                m_k_q     <= pk_d;
                                m_last_q  <= s_last;
                                fx_q      <= '0;
                                fk_q      <= '0;
                                cnt_q     <= '0;
                            end else begin
                                fx_q        <= px_d;
                                fk_q        <= pk_d;
                                hold_last_q <= s_last;
                                state_q     <= HOLD;
                            end
                        end else begin
                            fx_q  <= px_d;
                            fk_q  <= pk_d;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        m_valid_q <= 1'b1;
                        m_x_q     <= fx_q;
                        m_k_q     <= fk_q;
                        m_last_q  <= hold_last_q;
                        fx_q      <= '0;
                        fk_q      <= '0;
                        cnt_q     <= '0;
                        state_q   <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_k     = m_k_q;
    assign m_last  = m_last_q;
    assign y_valid = dv_q[LATENCY-1];
    assign y_last  = dl_q[LATENCY-1];

endmodule
